// File: rtl/dram_write_packer_if.sv
// Handshake bundle between the pipeline/Conf side and dram_write_packer.
// master: the side driving config, input beats and OUT_READY.
// slave : the packer itself.
// Optional macro PACKER_STATS_EN adds the STALL_CNT statistic.
interface dram_write_packer_if;
    logic        CONFIG_VALID;
    logic        CONFIG_READY;
    logic [31:0] CONFIG_NBYTES;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] IN_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [63:0] OUT_DATA;
    logic        DONE;
    logic [15:0] DROP_CNT;
`ifdef PACKER_STATS_EN
    logic [31:0] STALL_CNT;

    modport master (
        output CONFIG_VALID, CONFIG_NBYTES, IN_VALID, IN_DATA, OUT_READY,
        input  CONFIG_READY, IN_READY, OUT_VALID, OUT_DATA, DONE, DROP_CNT, STALL_CNT
    );
    modport slave (
        input  CONFIG_VALID, CONFIG_NBYTES, IN_VALID, IN_DATA, OUT_READY,
        output CONFIG_READY, IN_READY, OUT_VALID, OUT_DATA, DONE, DROP_CNT, STALL_CNT
    );
`else
    modport master (
        output CONFIG_VALID, CONFIG_NBYTES, IN_VALID, IN_DATA, OUT_READY,
        input  CONFIG_READY, IN_READY, OUT_VALID, OUT_DATA, DONE, DROP_CNT
    );
    modport slave (
        input  CONFIG_VALID, CONFIG_NBYTES, IN_VALID, IN_DATA, OUT_READY,
        output CONFIG_READY, IN_READY, OUT_VALID, OUT_DATA, DONE, DROP_CNT
    );
`endif
endinterface

// File: rtl/dram_write_packer.sv
// dram_write_packer: beat FIFO plus byte-count framer in front of DRAMWriter.
// Takes ceil(NBYTES/8) beats per frame, drops excess input, zero-pads the
// tail to a whole number of BURST_BEATS bursts and pulses DONE at frame end.
// Optional macro PACKER_STATS_EN adds a saturating output-stall counter.
module dram_write_packer #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 16,
    parameter int BURST_BEATS = 16
) (
    input logic               ACLK,
    input logic               ARESETN,
    dram_write_packer_if.slave bus
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [29:0] BURST_MASK = 30'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_PAD    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Number of 8-byte beats needed to hold nbytes; 33-bit sum so 2^32-1 cannot wrap.
    function automatic logic [29:0] calc_beats(input logic [31:0] nbytes);
        return 30'(({1'b0, nbytes} + 33'd7) >> 3);
    endfunction

    // Beat count rounded up to the burst granule.
    function automatic logic [29:0] calc_total(input logic [29:0] beats);
        return (beats + BURST_MASK) & ~BURST_MASK;
    endfunction

    state_t            state_r, state_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r, rd_ptr_r;
    logic [29:0]       beats_r, total_r, wr_cnt_r, rd_cnt_r;
    logic [15:0]       drop_cnt_r;
    logic [29:0]       cfg_beats_s;

    logic              full_s, empty_s, push_s, pop_s, drop_s, cfg_acc_s, in_ready_s;
    logic [DATA_W-1:0] push_data_s;

    assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign pop_s       = !empty_s && bus.OUT_READY;
    assign cfg_beats_s = calc_beats(bus.CONFIG_NBYTES);

    // Next-state and per-cycle control decode of the frame FSM.
    always_comb begin
        state_s     = state_r;
        push_s      = 1'b0;
        push_data_s = {DATA_W{1'b0}};
        drop_s      = 1'b0;
        cfg_acc_s   = 1'b0;
        in_ready_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.CONFIG_VALID) begin
                    cfg_acc_s = 1'b1;
                    if (cfg_beats_s == 30'd0) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_STREAM;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_STREAM: begin
                in_ready_s  = !full_s;
                push_s      = bus.IN_VALID && !full_s;
                push_data_s = bus.IN_DATA;
                if (push_s && ((wr_cnt_r + 30'd1) == beats_r)) begin
                    state_s = (total_r > beats_r) ? S_PAD : S_DRAIN;
                end else begin
                    state_s = S_STREAM;
                end
            end
            S_PAD: begin
                in_ready_s = 1'b1;
                drop_s     = bus.IN_VALID;
                push_s     = !full_s;
                if (push_s && ((wr_cnt_r + 30'd1) == total_r)) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_PAD;
                end
            end
            S_DRAIN: begin
                in_ready_s = 1'b1;
                drop_s     = bus.IN_VALID;
                if ((rd_cnt_r == total_r) && empty_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO storage; contents are only visible through the empty-gated read port.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Frame length latch and beat counters, restarted on each accepted config.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beats_r  <= 30'd0;
            total_r  <= 30'd0;
            wr_cnt_r <= 30'd0;
            rd_cnt_r <= 30'd0;
        end else if (cfg_acc_s) begin
            beats_r  <= cfg_beats_s;
            total_r  <= calc_total(cfg_beats_s);
            wr_cnt_r <= 30'd0;
            rd_cnt_r <= 30'd0;
        end else begin
            if (push_s) begin
                wr_cnt_r <= wr_cnt_r + 30'd1;
            end
            if (pop_s) begin
                rd_cnt_r <= rd_cnt_r + 30'd1;
            end
        end
    end

    // Saturating count of excess input beats discarded in the current frame.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            drop_cnt_r <= 16'd0;
        end else if (cfg_acc_s) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

`ifdef PACKER_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles where DRAMWriter back-pressures a valid beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stall_cnt_r <= 32'd0;
        end else if (cfg_acc_s) begin
            stall_cnt_r <= 32'd0;
        end else if (!empty_s && !bus.OUT_READY && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign bus.STALL_CNT = stall_cnt_r;
`endif

    assign bus.CONFIG_READY = (state_r == S_IDLE);
    assign bus.IN_READY     = in_ready_s;
    assign bus.OUT_VALID    = !empty_s;
    assign bus.OUT_DATA     = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
    assign bus.DONE         = (state_r == S_DONE);
    assign bus.DROP_CNT     = drop_cnt_r;

endmodule
